// File: rtl/keychain_pkg.sv
// Shared definitions for the key-generation arithmetic blocks.
// Holds the default operand width and the mod_exp controller state encoding.
package keychain_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REDUCE,
        ST_REDUCE_WAIT,
        ST_SQR,
        ST_SQR_WAIT,
        ST_MUL,
        ST_MUL_WAIT,
        ST_NEXT,
        ST_DONE
    } exp_state_t;

endpackage

// File: rtl/mod_exp_if.sv
// Request/response bundle for mod_exp: operands and start in, result and status out.
interface mod_exp_if import keychain_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) ();
    logic             ready_in;
    logic [WIDTH-1:0] base_in;
    logic [WIDTH-1:0] exponent_in;
    logic [WIDTH-1:0] modulus_in;
    logic [WIDTH-1:0] result_out;
    logic             busy_out;
    logic             valid_out;
    logic             error_out;

    modport master (
        output ready_in, base_in, exponent_in, modulus_in,
        input  result_out, busy_out, valid_out, error_out
    );

    modport slave (
        input  ready_in, base_in, exponent_in, modulus_in,
        output result_out, busy_out, valid_out, error_out
    );
endinterface

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: p = a*b mod m, MSB of a first.
// The first bit is folded into the start cycle so done lands WIDTH cycles after start.
module mod_mul_serial import keychain_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH-1:0] p_out,
    output logic             done_out
);
    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] a_reg, b_reg, m_reg;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH:0]   r_next;
    logic [IDX_W-1:0] idx_reg;
    logic             run_reg;
    logic             done_reg;

    // One interleaved step; the extra bit holds 2r and r+b, both <= 2m-2.
    function automatic logic [WIDTH:0] mod_step(
        input logic [WIDTH:0]   r,
        input logic             a_bit,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] t;
        logic [WIDTH:0] mx;
        mx = {1'b0, m};
        t  = r << 1;
        if (t >= mx) t = t - mx;
        if (a_bit)   t = t + {1'b0, b};
        if (t >= mx) t = t - mx;
        return t;
    endfunction

    always_comb begin
        r_next = r_reg;
        if (start_in)
            r_next = mod_step('0, a_in[WIDTH-1], b_in, m_in);
        else if (run_reg)
            r_next = mod_step(r_reg, a_reg[idx_reg], b_reg, m_reg);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_reg    <= '0;
            b_reg    <= '0;
            m_reg    <= '0;
            r_reg    <= '0;
            idx_reg  <= '0;
            run_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else if (start_in) begin
            a_reg    <= a_in;
            b_reg    <= b_in;
            m_reg    <= m_in;
            r_reg    <= r_next;
            idx_reg  <= IDX_W'(WIDTH - 2);
            run_reg  <= 1'b1;
            done_reg <= 1'b0;
        end else if (run_reg) begin
            r_reg    <= r_next;
            done_reg <= (idx_reg == '0);
            if (idx_reg == '0)
                run_reg <= 1'b0;
            else
                idx_reg <= idx_reg - 1'b1;
        end else begin
            done_reg <= 1'b0;
        end
    end

    assign p_out    = r_reg[WIDTH-1:0];
    assign done_out = done_reg;

endmodule

// File: rtl/mod_exp.sv
// Modular exponentiation by left-to-right square-and-multiply over one serial multiplier.
// Every exponent bit is visited, so latency depends only on the exponent popcount.
module mod_exp import keychain_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    mod_exp_if.slave   bus
);
    localparam int IDX_W = $clog2(WIDTH);

    exp_state_t       state_reg, state_next;
    logic [WIDTH-1:0] base_reg, base_next;
    logic [WIDTH-1:0] exp_reg, exp_next;
    logic [WIDTH-1:0] mod_reg, mod_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             busy_reg, busy_next;
    logic             valid_reg, valid_next;
    logic             error_reg, error_next;

    logic             mul_start;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic [WIDTH-1:0] mul_p;
    logic             mul_done;

    mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start_in (mul_start),
        .a_in     (mul_a),
        .b_in     (mul_b),
        .m_in     (mod_reg),
        .p_out    (mul_p),
        .done_out (mul_done)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg  <= ST_IDLE;
            base_reg   <= '0;
            exp_reg    <= '0;
            mod_reg    <= '0;
            acc_reg    <= '0;
            idx_reg    <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            base_reg   <= base_next;
            exp_reg    <= exp_next;
            mod_reg    <= mod_next;
            acc_reg    <= acc_next;
            idx_reg    <= idx_next;
            result_reg <= result_next;
            busy_reg   <= busy_next;
            valid_reg  <= valid_next;
            error_reg  <= error_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        base_next   = base_reg;
        exp_next    = exp_reg;
        mod_next    = mod_reg;
        acc_next    = acc_reg;
        idx_next    = idx_reg;
        result_next = result_reg;
        busy_next   = busy_reg;
        valid_next  = 1'b0;
        error_next  = error_reg;
        mul_start   = 1'b0;
        mul_a       = acc_reg;
        mul_b       = acc_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (bus.ready_in) begin
                    base_next  = bus.base_in;
                    exp_next   = bus.exponent_in;
                    mod_next   = bus.modulus_in;
                    busy_next  = 1'b1;
                    error_next = 1'b0;
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mod_reg == '0) begin
                    error_next = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    // Anything mod 1 is 0, so seed the accumulator accordingly.
                    acc_next   = (mod_reg == WIDTH'(1)) ? '0 : WIDTH'(1);
                    idx_next   = IDX_W'(WIDTH - 1);
                    state_next = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                mul_start  = 1'b1;
                mul_a      = base_reg;
                mul_b      = WIDTH'(1);
                state_next = ST_REDUCE_WAIT;
            end
            ST_REDUCE_WAIT: begin
                if (mul_done) begin
                    base_next  = mul_p;
                    state_next = ST_SQR;
                end
            end
            ST_SQR: begin
                mul_start  = 1'b1;
                state_next = ST_SQR_WAIT;
            end
            ST_SQR_WAIT: begin
                if (mul_done) begin
                    acc_next = mul_p;
                    if (exp_reg[idx_reg])
                        state_next = ST_MUL;
                    else if (idx_reg == '0)
                        state_next = ST_NEXT;
                    else begin
                        idx_next   = idx_reg - 1'b1;
                        state_next = ST_SQR;
                    end
                end
            end
            ST_MUL: begin
                mul_start  = 1'b1;
                mul_b      = base_reg;
                state_next = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (mul_done) begin
                    acc_next = mul_p;
                    if (idx_reg == '0)
                        state_next = ST_NEXT;
                    else begin
                        idx_next   = idx_reg - 1'b1;
                        state_next = ST_SQR;
                    end
                end
            end
            ST_NEXT: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                result_next = error_reg ? '0 : acc_reg;
                valid_next  = 1'b1;
                busy_next   = 1'b0;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.result_out = result_reg;
    assign bus.busy_out   = busy_reg;
    assign bus.valid_out  = valid_reg;
    assign bus.error_out  = error_reg;

endmodule

// File: tb/tb_mod_exp.sv
// Directed and reference-model bench for mod_exp: results, latency, handshake, error and reset.
module tb_mod_exp;
    localparam int W = 16;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    mod_exp_if #(.WIDTH(W)) bus ();

    mod_exp #(.WIDTH(W)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    typedef struct {
        logic [15:0] b;
        logic [15:0] e;
        logic [15:0] m;
        logic [15:0] res;
        logic        err;
        int          pulse;
    } vec_t;

    vec_t        vecs [8];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] prev_res = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int popcount16(input logic [15:0] v);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(v[i]);
        return c;
    endfunction

    // Right-to-left reference with native arithmetic.
    function automatic logic [15:0] ref_pow(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
        longint unsigned r, x, mm;
        if (m == 16'd0) return 16'd0;
        mm = longint'(m);
        r  = 64'd1 % mm;
        x  = longint'(b) % mm;
        for (int i = 0; i < 16; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[15:0];
    endfunction

    // Called #1 after a rising edge; ready is driven for the cycle that follows.
    task automatic run_op(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                          input logic [15:0] exp_res, input logic exp_err, input int pulse_at,
                          input string tag);
        int lat_req;
        int n;
        bit seen, busy_ok, held_ok;
        lat_req = (m == 16'd0) ? 2 : (1 + W + popcount16(e)) * (W + 1) + 3;
        bus.base_in     = b;
        bus.exponent_in = e;
        bus.modulus_in  = m;
        bus.ready_in    = 1'b1;
        @(posedge clk_in); #1;
        bus.ready_in    = 1'b0;
        bus.base_in     = 16'($urandom);
        bus.exponent_in = 16'($urandom);
        bus.modulus_in  = 16'($urandom);
        check({tag, "_busy_after_accept"}, 32'(bus.busy_out), 32'd1);
        check({tag, "_err_clear_on_accept"}, 32'(bus.error_out), 32'd0);
        n = 0; seen = 0; busy_ok = 1; held_ok = 1;
        while (!seen && n < 2000) begin
            bus.ready_in = (n == pulse_at);
            @(posedge clk_in); #1;
            n++;
            if (bus.valid_out) seen = 1;
            else begin
                if (!bus.busy_out) busy_ok = 0;
                if (bus.result_out !== prev_res) held_ok = 0;
            end
        end
        bus.ready_in = 1'b0;
        check({tag, "_valid_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(lat_req));
        check({tag, "_result"}, 32'(bus.result_out), 32'(exp_res));
        check({tag, "_error"}, 32'(bus.error_out), 32'(exp_err));
        check({tag, "_busy_low_at_valid"}, 32'(bus.busy_out), 32'd0);
        check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        check({tag, "_prev_result_held"}, 32'(held_ok), 32'd1);
        $display("op %s base=%0d exp=%0d mod=%0d result=%0d err=%0d latency=%0d",
                 tag, b, e, m, bus.result_out, bus.error_out, n);
        @(posedge clk_in); #1;
        check({tag, "_valid_single_pulse"}, 32'(bus.valid_out), 32'd0);
        check({tag, "_result_stable"}, 32'(bus.result_out), 32'(exp_res));
        prev_res = exp_res;
    endtask

    initial begin
        int pulses;
        logic [15:0] rb, re, rm;

        vecs[0] = '{b: 16'd4,     e: 16'd13,    m: 16'd497,   res: 16'd445, err: 1'b0, pulse: -1};
        vecs[1] = '{b: 16'd3,     e: 16'd0,     m: 16'd7,     res: 16'd1,   err: 1'b0, pulse: -1};
        vecs[2] = '{b: 16'd5,     e: 16'd3,     m: 16'd1,     res: 16'd0,   err: 1'b0, pulse: -1};
        vecs[3] = '{b: 16'd1000,  e: 16'd2,     m: 16'd7,     res: 16'd1,   err: 1'b0, pulse: -1};
        vecs[4] = '{b: 16'd2,     e: 16'd10,    m: 16'd1000,  res: 16'd24,  err: 1'b0, pulse: 40};
        vecs[5] = '{b: 16'd9,     e: 16'd5,     m: 16'd0,     res: 16'd0,   err: 1'b1, pulse: -1};
        vecs[6] = '{b: 16'd2,     e: 16'd5,     m: 16'd13,    res: 16'd6,   err: 1'b0, pulse: -1};
        vecs[7] = '{b: 16'd65535, e: 16'd65535, m: 16'd65521, res: 16'd0,   err: 1'b0, pulse: 100};
        vecs[7].res = ref_pow(16'd65535, 16'd65535, 16'd65521);

        bus.ready_in    = 1'b0;
        bus.base_in     = '0;
        bus.exponent_in = '0;
        bus.modulus_in  = '0;

        #12;
        check("reset_result", 32'(bus.result_out), 32'd0);
        check("reset_busy",   32'(bus.busy_out),   32'd0);
        check("reset_valid",  32'(bus.valid_out),  32'd0);
        check("reset_error",  32'(bus.error_out),  32'd0);
        @(negedge clk_in); rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].b, vecs[i].e, vecs[i].m, vecs[i].res, vecs[i].err, vecs[i].pulse,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 60; i++) begin
            rb = 16'($urandom);
            re = 16'($urandom);
            rm = 16'($urandom_range(1, 65535));
            run_op(rb, re, rm, ref_pow(rb, re, rm), 1'b0, 50, $sformatf("rand%0d", i));
        end

        // Abort mid-operation while the controller is in the squaring phase.
        bus.base_in = 16'd4; bus.exponent_in = 16'd13; bus.modulus_in = 16'd497;
        bus.ready_in = 1'b1;
        @(posedge clk_in); #1;
        bus.ready_in = 1'b0;
        repeat (30) @(posedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        check("midreset_result", 32'(bus.result_out), 32'd0);
        check("midreset_busy",   32'(bus.busy_out),   32'd0);
        check("midreset_valid",  32'(bus.valid_out),  32'd0);
        check("midreset_error",  32'(bus.error_out),  32'd0);
        $display("op midreset result=%0d busy=%0d", bus.result_out, bus.busy_out);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in); rst_n_in = 1'b1;
        prev_res = 16'd0;
        pulses = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_in); #1;
            if (bus.valid_out) pulses++;
        end
        check("midreset_no_valid", 32'(pulses), 32'd0);
        check("midreset_idle_busy", 32'(bus.busy_out), 32'd0);
        run_op(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, -1, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
